dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate data cache directly downstream of the core's memory stage.
- Consumes the core's dcache_addr / dcache_we / dcache_re / dcache_din.
- Returns dcache_dout and drives the core's stall input.
- Talks to main memory over a 128-bit line-wide valid/ready request port and a valid-only response port.

Parameters:
- LINES, 64, number of cache lines; power of two ≥2; index = addr[3+log2(LINES):4].
- ADDR_W, 32, byte-address width; tag = addr[ADDR_W-1:4+log2(LINES)].

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all valid bits and FSM
- cpu_addr  in  32  byte address from memory stage (core dcache_addr)
- cpu_re  in  1  load request
- cpu_we  in  4  store byte mask; nonzero = store; cpu_re and cpu_we≠0 never together
- cpu_din  in  32  store data, byte lanes already aligned
- cpu_dout  out  32  load data (core dcache_dout)
- stall  out  1  core must hold all cpu_* inputs stable while high
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_rw  out  1  1 = write, 0 = line read
- mem_req_addr  out  28  line address addr[31:4]
- mem_req_data  out  128  write data; store word replicated into all four lanes
- mem_req_mask  out  16  byte mask; only the addressed word's 4 bits may be set
- mem_resp_valid  in  1  refill data valid, exactly one beat per read
- mem_resp_data  in  128  refill line; word w in bits [32w+31:32w]

Behaviour:
- Storage: data array LINES×128 flops; tag array; valid bit per line. No reset of data or tag arrays.
- Request capture: on each edge with stall=0, register {addr, re, we, din} into req_q. The lookup uses req_q (SRAM-like, 1-cycle latency).
- IDLE, req_q empty: stall=0.
- IDLE, load hit (valid & tag match): cpu_dout = addressed word in the cycle after issue; stall=0. Back-to-back hits sustain one per cycle.
- IDLE, load miss: stall=1 combinationally in the same cycle; go to RD_REQ.
- IDLE, store: hit → merge bytes per cpu_we into the line at the edge leaving IDLE; miss → line untouched. Either way stall=1; go to WR_REQ.
- RD_REQ: mem_req_valid=1, rw=0, addr=req line.
  - Ready → RD_WAIT.
- RD_WAIT: wait mem_resp_valid.
  - On it: write line, tag, set valid; go to RESP.
  - mem_resp_valid outside RD_WAIT is ignored.
- RESP: stall=0; cpu_dout = requested word from the refilled line; the core advances; return to IDLE, capturing the next request this edge.
- WR_REQ: mem_req_valid=1, rw=1, data/mask per store.
  - Ready → IDLE with stall=0 in that same cycle.
- mem_req_* stay stable while mem_req_valid=1 and mem_req_ready=0.
- stall is high in RD_REQ, RD_WAIT, WR_REQ, and in IDLE on miss or store detection.
- cpu_dout holds its last value whenever no load completes.
- Reset values: stall=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0, mem_req_mask=0, cpu_dout=0, req_q empty, FSM=IDLE, all valid=0.
- Reset asserted mid-refill or mid-write: abandon the transaction immediately. No line is partially written.

Optional Feature:
- Macro: DCACHE_WBUF_EN.
- Defined: adds a one-entry store buffer.
  - A store with the buffer empty completes in IDLE with stall=0; the cache update is identical to the baseline.
  - The buffer drains via the mem write port whenever the FSM is IDLE.
  - Stall on a store only if the buffer is full.
  - A load miss first drains the buffer, then issues the refill, so memory order is preserved.
  - A load hit to the buffered word returns the already-merged cache data.
- Undefined: baseline behaviour; every store stalls until accepted.

Test Plan:
- Reset (0), then load 0x0000_0100 → stall=1, mem_req_addr=0x0000010, rw=0. Respond with word0=0xDEADBEEF → stall drops in RESP, cpu_dout=0xDEADBEEF.
- Reload 0x100, then 0x104 back-to-back → no stall; dout 0xDEADBEEF then word1, one per cycle.
- Store 0x100, we=4'b0011, din=0x0000_1234 → mem_req_mask=16'h0003, rw=1. Stall held while ready=0 for 3 cycles. A later load of 0x100 hits with 0xDEAD1234.
- Store miss to 0x2000 → mem write issued, no refill. Load 0x2000 then misses, refill requested.
- Conflict: refill 0x100, then load 0x500 (same index 16, different tag) → miss, refill. Load 0x100 → misses again.
- Assert reset during RD_WAIT → stall=0, mem_req_valid=0 at once. After release, load 0x100 → misses.

Source files
------------

// File: rtl/dcache_wt_if.sv
// Line-wide memory port of the write-through data cache.
// master = cache side (issues requests, receives refills), slave = memory side.
interface dcache_wt_if #(
   parameter int ADDR_W = 32
);
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic                mem_req_rw;
   logic [ADDR_W-5:0]   mem_req_addr;
   logic [127:0]        mem_req_data;
   logic [15:0]         mem_req_mask;
   logic                mem_resp_valid;
   logic [127:0]        mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/dcache_wt.sv
// Blocking, direct-mapped, write-through, no-write-allocate data cache.
// Requests are registered into req_q on every non-stalled edge and looked up
// one cycle later. Misses refill a whole 128-bit line; stores always go to
// memory, and update the cache only when they hit.
// Optional macro DCACHE_WBUF_EN adds a one-entry store buffer so stores to an
// empty buffer complete without stalling.
module dcache_wt #(
   parameter int LINES  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_re,
   input  logic [3:0]        cpu_we,
   input  logic [31:0]       cpu_din,
   output logic [31:0]       cpu_dout,
   output logic              stall,
   dcache_wt_if.master       mem
);

   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - 4 - IW;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RESP, WR_REQ} state_t;

   // addr holds the word address; the byte offset never affects the cache
   typedef struct packed {
      logic [ADDR_W-3:0] addr;
      logic              re;
      logic [3:0]        we;
      logic [31:0]       din;
   } req_t;

   state_t state, state_nxt;
   req_t   req_q;

   logic [127:0]    data_q [LINES];
   logic [TW-1:0]   tag_q  [LINES];
   logic [LINES-1:0] valid_q;
   logic [31:0]     dout_q;

   logic [IW-1:0]   idx;
   logic [TW-1:0]   tag;
   logic [1:0]      word;
   logic [127:0]    rd_line;
   logic [31:0]     rd_word;
   logic            hit;
   logic            is_st;

   logic [127:0]    st_data;
   logic [15:0]     st_mask;
   logic [127:0]    merged;

   logic            load_done;
   logic            refill_we;
   logic            store_commit;
   logic            merge_we;

   logic            req_valid;
   logic            req_rw;
   logic [ADDR_W-5:0] req_addr;
   logic [127:0]    req_data;
   logic [15:0]     req_mask;

   logic            unused_ok;
   assign unused_ok = ^cpu_addr[1:0];

`ifdef DCACHE_WBUF_EN
   logic              wbuf_v;
   logic [ADDR_W-5:0] wbuf_addr;
   logic [127:0]      wbuf_data;
   logic [15:0]       wbuf_mask;
   logic              wbuf_load;
`endif

   // lookup fields of the captured request
   assign word    = req_q.addr[1:0];
   assign idx     = req_q.addr[2 +: IW];
   assign tag     = req_q.addr[ADDR_W-3 -: TW];
   assign rd_line = data_q[idx];
   assign rd_word = rd_line[{word, 5'b0} +: 32];
   assign hit     = valid_q[idx] && (tag_q[idx] == tag);
   assign is_st   = |req_q.we;
   assign merge_we = store_commit && hit;

   // store word replicated in all lanes; mask only on the addressed word
   always_comb begin
      st_data = {4{req_q.din}};
      st_mask = '0;
      st_mask[{word, 2'b00} +: 4] = req_q.we;
      merged = rd_line;
      for (int b = 0; b < 16; b++) begin
         if (st_mask[b]) merged[b*8 +: 8] = st_data[b*8 +: 8];
      end
   end

   // request capture: the core advances on every edge without stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) req_q <= '0;
      else if (!stall) req_q <= '{addr: cpu_addr[ADDR_W-1:2], re: cpu_re, we: cpu_we, din: cpu_din};
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state, stall and memory request outputs
   always_comb begin
      state_nxt    = state;
      stall        = 1'b0;
      load_done    = 1'b0;
      refill_we    = 1'b0;
      store_commit = 1'b0;
      req_valid    = 1'b0;
      req_rw       = 1'b0;
      req_addr     = '0;
      req_data     = '0;
      req_mask     = '0;
`ifdef DCACHE_WBUF_EN
      wbuf_load    = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef DCACHE_WBUF_EN
            // the buffer drains whenever the FSM sits in IDLE
            if (wbuf_v) begin
               req_valid = 1'b1;
               req_rw    = 1'b1;
               req_addr  = wbuf_addr;
               req_data  = wbuf_data;
               req_mask  = wbuf_mask;
            end
`endif
            if (req_q.re) begin
               if (hit) begin
                  load_done = 1'b1;
               end else begin
                  stall = 1'b1;
`ifdef DCACHE_WBUF_EN
                  // pending store must reach memory before the refill
                  if (!wbuf_v) state_nxt = RD_REQ;
`else
                  state_nxt = RD_REQ;
`endif
               end
            end else if (is_st) begin
`ifdef DCACHE_WBUF_EN
               if (!wbuf_v) begin
                  store_commit = 1'b1;
                  wbuf_load    = 1'b1;
               end else begin
                  stall = 1'b1;
               end
`else
               stall        = 1'b1;
               store_commit = 1'b1;
               state_nxt    = WR_REQ;
`endif
            end
         end
         RD_REQ: begin
            stall     = 1'b1;
            req_valid = 1'b1;
            req_addr  = req_q.addr[ADDR_W-3:2];
            if (mem.mem_req_ready) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            stall = 1'b1;
            if (mem.mem_resp_valid) begin
               refill_we = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            load_done = 1'b1;
            state_nxt = IDLE;
         end
         WR_REQ: begin
            req_valid = 1'b1;
            req_rw    = 1'b1;
            req_addr  = req_q.addr[ADDR_W-3:2];
            req_data  = st_data;
            req_mask  = st_mask;
            if (mem.mem_req_ready) state_nxt = IDLE;
            else                   stall     = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem.mem_req_valid = req_valid;
   assign mem.mem_req_rw    = req_rw;
   assign mem.mem_req_addr  = req_addr;
   assign mem.mem_req_data  = req_data;
   assign mem.mem_req_mask  = req_mask;

`ifdef DCACHE_WBUF_EN
   // store buffer: filled by a committing store, emptied on acceptance
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbuf_v    <= 1'b0;
         wbuf_addr <= '0;
         wbuf_data <= '0;
         wbuf_mask <= '0;
      end else if (wbuf_load) begin
         wbuf_v    <= 1'b1;
         wbuf_addr <= req_q.addr[ADDR_W-3:2];
         wbuf_data <= st_data;
         wbuf_mask <= st_mask;
      end else if (wbuf_v && state == IDLE && mem.mem_req_ready) begin
         wbuf_v <= 1'b0;
      end
   end
`endif

   // data and tag arrays: refill writes whole line, store hit merges bytes
   always_ff @(posedge clk) begin
      if (refill_we) begin
         data_q[idx] <= mem.mem_resp_data;
         tag_q[idx]  <= tag;
      end else if (merge_we) begin
         data_q[idx] <= merged;
      end
   end

   // valid bits are the only array state that reset clears
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         valid_q      <= '0;
      else if (refill_we) valid_q[idx] <= 1'b1;
   end

   // load data register holds the last completed load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         dout_q <= '0;
      else if (load_done) dout_q <= rd_word;
   end

   assign cpu_dout = load_done ? rd_word : dout_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt (default build).
module tb_dcache_wt;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_re;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic        stall;

   int errs   = 0;
   int checks = 0;

   dcache_wt_if #(.ADDR_W(32)) mem_bus ();

   dcache_wt #(.LINES(64), .ADDR_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_addr (cpu_addr),
      .cpu_re   (cpu_re),
      .cpu_we   (cpu_we),
      .cpu_din  (cpu_din),
      .cpu_dout (cpu_dout),
      .stall    (stall),
      .mem      (mem_bus)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] LINE_A = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hDEADBEEF};
   localparam logic [127:0] LINE_B = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
   localparam logic [127:0] LINE_C = {32'hC0C00003, 32'hC0C00002, 32'hC0C00001, 32'hC0C00000};
   localparam logic [127:0] LINE_D = {32'hD0D00003, 32'hD0D00002, 32'hD0D00001, 32'hD0D00000};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // full miss sequence: capture, RD_REQ, accept, RD_WAIT, refill, RESP, IDLE
   task automatic miss_load(input logic [31:0] a, input logic [127:0] line, input logic [31:0] exp);
      cpu_re = 1'b1; cpu_we = 4'b0; cpu_addr = a;
      tick();
      cpu_re = 1'b0;
      chk("miss_stall", 128'(stall), 128'(1'b1));
      chk("miss_idle_valid", 128'(mem_bus.mem_req_valid), 128'(1'b0));
      tick();
      chk("rd_valid", 128'(mem_bus.mem_req_valid), 128'(1'b1));
      chk("rd_rw", 128'(mem_bus.mem_req_rw), 128'(1'b0));
      chk("rd_addr", 128'(mem_bus.mem_req_addr), 128'(a[31:4]));
      mem_bus.mem_req_ready = 1'b1;
      tick();
      mem_bus.mem_req_ready = 1'b0;
      chk("rdw_stall", 128'(stall), 128'(1'b1));
      chk("rdw_valid", 128'(mem_bus.mem_req_valid), 128'(1'b0));
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = line;
      tick();
      mem_bus.mem_resp_valid = 1'b0;
      chk("resp_stall", 128'(stall), 128'(1'b0));
      chk("resp_dout", 128'(cpu_dout), 128'(exp));
      tick();
      chk("resp_hold", 128'(cpu_dout), 128'(exp));
      chk("resp_idle_stall", 128'(stall), 128'(1'b0));
   endtask

   task automatic hit_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
      cpu_re = 1'b1; cpu_we = 4'b0; cpu_addr = a;
      tick();
      cpu_re = 1'b0;
      chk({tag, "_stall"}, 128'(stall), 128'(1'b0));
      chk({tag, "_dout"}, 128'(cpu_dout), 128'(exp));
   endtask

   initial begin
      reset = 1'b0;
      cpu_addr = '0; cpu_re = 1'b0; cpu_we = '0; cpu_din = '0;
      mem_bus.mem_req_ready  = 1'b0;
      mem_bus.mem_resp_valid = 1'b0;
      mem_bus.mem_resp_data  = '0;
      repeat (2) tick();

      // reset state
      chk("rst_stall", 128'(stall), 128'(1'b0));
      chk("rst_valid", 128'(mem_bus.mem_req_valid), 128'(1'b0));
      chk("rst_rw", 128'(mem_bus.mem_req_rw), 128'(1'b0));
      chk("rst_addr", 128'(mem_bus.mem_req_addr), 128'(0));
      chk("rst_data", mem_bus.mem_req_data, 128'(0));
      chk("rst_mask", 128'(mem_bus.mem_req_mask), 128'(0));
      chk("rst_dout", 128'(cpu_dout), 128'(0));
      reset = 1'b1;
      tick();

      // first load misses and refills
      miss_load(32'h0000_0100, LINE_A, 32'hDEADBEEF);

      // back-to-back hits, one per cycle, then hold
      cpu_re = 1'b1; cpu_addr = 32'h0000_0100;
      tick();
      chk("b2b0_stall", 128'(stall), 128'(1'b0));
      chk("b2b0_dout", 128'(cpu_dout), 128'(32'hDEADBEEF));
      cpu_addr = 32'h0000_0104;
      tick();
      chk("b2b1_stall", 128'(stall), 128'(1'b0));
      chk("b2b1_dout", 128'(cpu_dout), 128'(32'hCAFE0001));
      cpu_addr = 32'h0000_010C;
      tick();
      chk("b2b3_dout", 128'(cpu_dout), 128'(32'hCAFE0003));
      cpu_re = 1'b0;
      tick();
      chk("idle_hold", 128'(cpu_dout), 128'(32'hCAFE0003));

      // store hit with partial byte mask, memory slow to accept
      cpu_we = 4'b0011; cpu_addr = 32'h0000_0100; cpu_din = 32'h0000_1234;
      tick();
      cpu_we = 4'b0;
      chk("st_idle_stall", 128'(stall), 128'(1'b1));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_stall", 128'(stall), 128'(1'b1));
         chk("wr_valid", 128'(mem_bus.mem_req_valid), 128'(1'b1));
         chk("wr_rw", 128'(mem_bus.mem_req_rw), 128'(1'b1));
         chk("wr_mask", 128'(mem_bus.mem_req_mask), 128'(16'h0003));
         chk("wr_addr", 128'(mem_bus.mem_req_addr), 128'(28'h0000010));
         chk("wr_data", mem_bus.mem_req_data, {4{32'h0000_1234}});
      end
      mem_bus.mem_req_ready = 1'b1;
      #1;
      chk("wr_ready_stall", 128'(stall), 128'(1'b0));
      tick();
      mem_bus.mem_req_ready = 1'b0;
      chk("wr_done_valid", 128'(mem_bus.mem_req_valid), 128'(1'b0));
      hit_load("st_merged", 32'h0000_0100, 32'hDEAD1234);
      hit_load("st_other_word", 32'h0000_0108, 32'hCAFE0002);

      // store miss: write only, no allocation
      cpu_we = 4'b1111; cpu_addr = 32'h0000_2000; cpu_din = 32'hA5A5_A5A5;
      tick();
      cpu_we = 4'b0;
      chk("stm_stall", 128'(stall), 128'(1'b1));
      tick();
      chk("stm_valid", 128'(mem_bus.mem_req_valid), 128'(1'b1));
      chk("stm_rw", 128'(mem_bus.mem_req_rw), 128'(1'b1));
      chk("stm_addr", 128'(mem_bus.mem_req_addr), 128'(28'h0000200));
      chk("stm_mask", 128'(mem_bus.mem_req_mask), 128'(16'h000F));
      mem_bus.mem_req_ready = 1'b1;
      tick();
      mem_bus.mem_req_ready = 1'b0;

      // stray response outside RD_WAIT must be ignored
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data  = LINE_B;
      tick();
      mem_bus.mem_resp_valid = 1'b0;
      hit_load("stray_resp", 32'h0000_0100, 32'hDEAD1234);

      miss_load(32'h0000_2000, LINE_D, 32'hD0D00000);

      // conflict: same index 16, different tag evicts 0x100
      miss_load(32'h0000_0504, LINE_B, 32'hBBBB0001);
      miss_load(32'h0000_0100, LINE_A, 32'hDEADBEEF);

      // reset during RD_WAIT abandons the refill
      cpu_re = 1'b1; cpu_addr = 32'h0000_3000;
      tick();
      cpu_re = 1'b0;
      tick();
      mem_bus.mem_req_ready = 1'b1;
      tick();
      mem_bus.mem_req_ready = 1'b0;
      chk("pre_rst_stall", 128'(stall), 128'(1'b1));
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", 128'(stall), 128'(1'b0));
      chk("mid_rst_valid", 128'(mem_bus.mem_req_valid), 128'(1'b0));
      chk("mid_rst_dout", 128'(cpu_dout), 128'(0));
      tick();
      reset = 1'b1;
      tick();
      miss_load(32'h0000_0100, LINE_C, 32'hC0C00000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
